// File: rtl/nios2_ht18_wang_fu_de2_pio_keyin_if.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_ht18_wang_fu_de2_pio_keyin_if
//  Description : Avalon-MM slave bus and interrupt line of the key-input PIO.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nios2_ht18_wang_fu_de2_pio_keyin_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface
`default_nettype wire

// File: rtl/nios2_ht18_wang_fu_de2_pio_keyin.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_ht18_wang_fu_de2_pio_keyin
//  Description : Input PIO for DE2 keys/switches. Two-flop synchroniser,
//                optional per-bit debounce, sticky edge capture with
//                write-1-to-clear, maskable level interrupt, zero-wait reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios2_ht18_wang_fu_de2_pio_keyin #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] in_port,
    nios2_ht18_wang_fu_de2_pio_keyin_if.slave avs
);

    localparam logic [1:0] c_ADDR_DATA = 2'd0;
    localparam logic [1:0] c_ADDR_MASK = 2'd2;
    localparam logic [1:0] c_ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clear;
    logic             w_write;
    logic [31:0]      w_readdata;
    logic             w_unused_wdata;

    // Upper write-data bits beyond WIDTH carry no meaning for this block.
    assign w_unused_wdata = ^avs.writedata;

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            logic [WIDTH-1:0] r_deb;

            // No filtering: the synchronised value is taken every cycle.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_deb <= '0;
                end else begin
                    r_deb <= r_sync2;
                end
            end

            assign w_deb = r_deb;
        end else begin : g_debounce
            localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic [c_CNT_W-1:0] r_cnt;
                logic               r_deb_bit;

                // Accept a new level only after it has differed from the
                // filtered value for DEBOUNCE_CYCLES consecutive cycles.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_cnt     <= '0;
                        r_deb_bit <= 1'b0;
                    end else if (r_sync2[i] == r_deb_bit) begin
                        r_cnt     <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_cnt     <= '0;
                        r_deb_bit <= r_sync2[i];
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                    end
                end

                assign w_deb[i] = r_deb_bit;
            end
        end
    endgenerate

    // Edge selection from the current and previous filtered value.
    always_comb begin
        w_edge = '0;
        if (EDGE_TYPE == 0) begin
            w_edge = w_deb & ~r_prev;
        end else if (EDGE_TYPE == 1) begin
            w_edge = ~w_deb & r_prev;
        end else begin
            w_edge = w_deb ^ r_prev;
        end
    end

    assign w_write = avs.chipselect & ~avs.write_n;
    assign w_clear = (w_write && (avs.address == c_ADDR_EDGE)) ? avs.writedata[WIDTH-1:0] : '0;

    // Previous-value register; a new edge outranks a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev         <= '0;
            r_edge_capture <= '0;
        end else begin
            r_prev         <= w_deb;
            r_edge_capture <= (r_edge_capture & ~w_clear) | w_edge;
        end
    end

    // Interrupt mask register, written through address 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_mask <= '0;
        end else if (w_write && (avs.address == c_ADDR_MASK)) begin
            r_irq_mask <= avs.writedata[WIDTH-1:0];
        end
    end

    // Zero-wait read mux; unused bits and address 1 read as zero.
    always_comb begin
        w_readdata = '0;
        case (avs.address)
            c_ADDR_DATA: w_readdata[WIDTH-1:0] = w_deb;
            c_ADDR_MASK: w_readdata[WIDTH-1:0] = r_irq_mask;
            c_ADDR_EDGE: w_readdata[WIDTH-1:0] = r_edge_capture;
            default:     w_readdata            = '0;
        endcase
    end

    assign avs.readdata = w_readdata;
    assign avs.irq      = |(r_edge_capture & r_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_nios2_ht18_wang_fu_de2_pio_keyin.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios2_ht18_wang_fu_de2_pio_keyin
//  Description : Three PIO instances (falling/bypass, any/debounce 8,
//                rising/debounce 3) sharing stimulus, checked every cycle
//                against a delay-line behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2_ht18_wang_fu_de2_pio_keyin;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_port;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;

    int cfg_edge [N];
    int cfg_deb  [N];

    logic [31:0] rd [N];
    logic [N-1:0] irq_v;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: history of applied inputs (index 0 = newest) plus registers.
    logic [3:0] m_hist [N][16];
    logic [3:0] m_deb  [N];
    logic [3:0] m_prev [N];
    logic [3:0] m_cap  [N];
    logic [3:0] m_mask [N];

    nios2_ht18_wang_fu_de2_pio_keyin_if bus0 ();
    nios2_ht18_wang_fu_de2_pio_keyin_if bus1 ();
    nios2_ht18_wang_fu_de2_pio_keyin_if bus2 ();

    assign bus0.address = address;  assign bus0.chipselect = chipselect;
    assign bus0.write_n = write_n;  assign bus0.writedata  = writedata;
    assign bus1.address = address;  assign bus1.chipselect = chipselect;
    assign bus1.write_n = write_n;  assign bus1.writedata  = writedata;
    assign bus2.address = address;  assign bus2.chipselect = chipselect;
    assign bus2.write_n = write_n;  assign bus2.writedata  = writedata;

    assign rd[0] = bus0.readdata;  assign irq_v[0] = bus0.irq;
    assign rd[1] = bus1.readdata;  assign irq_v[1] = bus1.irq;
    assign rd[2] = bus2.readdata;  assign irq_v[2] = bus2.irq;

    nios2_ht18_wang_fu_de2_pio_keyin #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .in_port(in_port), .avs(bus0));
    nios2_ht18_wang_fu_de2_pio_keyin #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(8)) dut1 (
        .clk(clk), .reset(reset), .in_port(in_port), .avs(bus1));
    nios2_ht18_wang_fu_de2_pio_keyin #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(3)) dut2 (
        .clk(clk), .reset(reset), .in_port(in_port), .avs(bus2));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            for (int j = 0; j < 16; j++) m_hist[n][j] = 4'h0;
            m_deb[n] = 4'h0; m_prev[n] = 4'h0; m_cap[n] = 4'h0; m_mask[n] = 4'h0;
        end
    endtask

    // One clock edge. A bit's filtered value follows the pin value seen two
    // edges earlier once that value has persisted for the whole debounce window.
    task automatic model_step(input logic [3:0] pin, input logic [1:0] a, input logic cs,
                              input logic wn, input logic [31:0] wd);
        logic [3:0] nd, ed, clr;
        logic       v, stable;
        int         win;
        for (int n = 0; n < N; n++) begin
            for (int j = 15; j > 0; j--) m_hist[n][j] = m_hist[n][j-1];
            m_hist[n][0] = pin;
            win = (cfg_deb[n] == 0) ? 1 : cfg_deb[n];
            for (int i = 0; i < 4; i++) begin
                v = m_hist[n][2][i];
                stable = 1'b1;
                for (int j = 0; j < win; j++)
                    if (m_hist[n][2+j][i] != v) stable = 1'b0;
                nd[i] = (stable && v != m_deb[n][i]) ? v : m_deb[n][i];
            end
            case (cfg_edge[n])
                0:       ed = m_deb[n] & ~m_prev[n];
                1:       ed = ~m_deb[n] & m_prev[n];
                default: ed = m_deb[n] ^ m_prev[n];
            endcase
            clr = (cs && !wn && a == 2'd3) ? wd[3:0] : 4'h0;
            m_cap[n] = (m_cap[n] & ~clr) | ed;
            if (cs && !wn && a == 2'd2) m_mask[n] = wd[3:0];
            m_prev[n] = m_deb[n];
            m_deb[n]  = nd;
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp;
        for (int n = 0; n < N; n++) begin
            case (address)
                2'd0:    exp = {28'h0, m_deb[n]};
                2'd2:    exp = {28'h0, m_mask[n]};
                2'd3:    exp = {28'h0, m_cap[n]};
                default: exp = 32'h0;
            endcase
            check($sformatf("rd%0d_a%0d", n, address), rd[n], exp);
            check($sformatf("irq%0d", n), {31'h0, irq_v[n]}, {31'h0, |(m_cap[n] & m_mask[n])});
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step(in_port, address, chipselect, write_n, writedata);
        #1;
        compare_all();
    endtask

    task automatic bus_idle(input logic [1:0] a);
        address = a; chipselect = 1'b1; write_n = 1'b1; writedata = 32'h0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        cycle();
        bus_idle(a);
    endtask

    initial begin
        cfg_edge[0] = 1; cfg_deb[0] = 0;
        cfg_edge[1] = 2; cfg_deb[1] = 8;
        cfg_edge[2] = 0; cfg_deb[2] = 3;
        reset = 1'b1; in_port = 4'hF; bus_idle(2'd0); model_reset();
        repeat (3) cycle();
        check("reset_rd0", rd[0], 32'h0);
        reset = 1'b0;

        // Input held high through reset release
        repeat (12) cycle();
        bus_idle(2'd3); cycle();
        check("hold_high_fall", rd[0], 32'h0);
        check("hold_high_any",  rd[1], 32'hF);
        check("hold_high_rise", rd[2], 32'hF);
        bus_write(2'd3, 32'hF);
        check("w1c_all", rd[2], 32'h0);

        // Bypass latency of a falling edge on bit 0
        bus_idle(2'd0); in_port = 4'hE;
        cycle(); cycle();
        check("lat_k1", rd[0], 32'hF);
        cycle();
        check("lat_k2", rd[0], 32'hE);
        bus_idle(2'd3); cycle();
        check("cap_k3", rd[0], 32'h1);
        check("irq_masked", {31'h0, irq_v[0]}, 32'h0);

        // Mask, partial clear, full clear
        bus_write(2'd2, 32'hABCD_0001);
        check("irq_unmask", {31'h0, irq_v[0]}, 32'h1);
        address = 2'd2; #1;
        check("mask_rd", rd[0], 32'h1);
        bus_write(2'd3, 32'h2);
        check("w1c_other", rd[0], 32'h1);
        bus_write(2'd3, 32'h1);
        check("w1c_bit0", rd[0], 32'h0);
        check("irq_cleared", {31'h0, irq_v[0]}, 32'h0);

        // Set wins over a same-cycle clear
        in_port = 4'hF; repeat (4) cycle();
        in_port = 4'hE; repeat (4) cycle();
        check("cap_again", rd[0], 32'h1);
        in_port = 4'hF; repeat (4) cycle();
        in_port = 4'hE; repeat (3) cycle();
        bus_write(2'd3, 32'h1);
        check("set_wins", rd[0], 32'h1);
        check("set_wins_irq", {31'h0, irq_v[0]}, 32'h1);

        // Debounce: short glitch rejected, long pulse accepted
        bus_idle(2'd0); in_port = 4'hF; repeat (14) cycle();
        bus_write(2'd3, 32'hF);
        bus_idle(2'd0);
        in_port = 4'hB; repeat (5) cycle();
        in_port = 4'hF; repeat (15) cycle();
        check("glitch_deb", rd[1], 32'hF);
        bus_idle(2'd3); cycle();
        check("glitch_cap", rd[1], 32'h0);
        bus_idle(2'd0); in_port = 4'hB;
        repeat (9) cycle();
        check("deb_k8", rd[1], 32'hF);
        cycle();
        check("deb_k9", rd[1], 32'hB);
        bus_idle(2'd3); cycle();
        check("deb_cap", rd[1], 32'h4);
        repeat (9) cycle();
        in_port = 4'hF; repeat (12) cycle();

        // Any-edge capture on bit 3 in both directions
        bus_write(2'd3, 32'hF);
        in_port = 4'h7; repeat (12) cycle();
        check("any_fall", rd[1], 32'h8);
        bus_write(2'd3, 32'hF);
        check("any_clr", rd[1], 32'h0);
        in_port = 4'hF; repeat (12) cycle();
        check("any_rise", rd[1], 32'h8);
        bus_idle(2'd1); cycle();
        check("addr1_zero", rd[1], 32'h0);
        bus_write(2'd0, 32'h5);
        check("addr0_ro", rd[1], 32'hF);

        // Randomised traffic with occasional asynchronous reset pulses
        for (int c = 0; c < 3000; c++) begin
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            if ($urandom_range(0, 9) == 0) in_port = in_port ^ 4'($urandom_range(1, 15));
            if ($urandom_range(0, 399) == 0) begin
                #1 reset = 1'b1; model_reset();
                #1 compare_all();
                #1 reset = 1'b0;
            end
            cycle();
        end

        // Asynchronous reset mid-debounce with captures and mask set
        bus_write(2'd2, 32'hF);
        bus_idle(2'd3);
        in_port = 4'hF; repeat (12) cycle();
        in_port = 4'h0; repeat (12) cycle();
        check("pre_reset_irq", {31'h0, irq_v[0]}, 32'h1);
        in_port = 4'hF; repeat (5) cycle();
        #2 reset = 1'b1; model_reset();
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            for (int n = 0; n < N; n++) begin
                check($sformatf("async_rst_rd%0d_a%0d", n, a), rd[n], 32'h0);
                check($sformatf("async_rst_irq%0d", n), {31'h0, irq_v[n]}, 32'h0);
            end
        end
        repeat (2) cycle();
        reset = 1'b0;
        repeat (14) cycle();
        check("post_rst_rise", rd[2], 32'hF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
